// File: rtl/ped_request_conditioner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ped_request_conditioner_pkg
// Shared types, default timing constants and helpers for the pedestrian
// request conditioner.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package ped_request_conditioner_pkg;

   localparam int C_SYNC_STAGES     = 2;
   localparam int C_DEBOUNCE_CYCLES = 16;
   localparam int C_DB_W            = 5;
   localparam int C_COOLDOWN_CYCLES = 32;
   localparam int C_CD_W            = 6;

   typedef logic [7:0] coal_cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PENDING  = 2'd1,
      ST_SERVING  = 2'd2,
      ST_COOLDOWN = 2'd3
   } ped_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic coal_cnt_t sat_inc8(input coal_cnt_t v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ped_request_conditioner_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ped_request_conditioner_if
// Button / controller side signals of the pedestrian request conditioner.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface ped_request_conditioner_if;
   import ped_request_conditioner_pkg::*;

   logic      btn_raw;
   logic      ped_walk;
   logic      ped_request;
   logic      wait_lamp;
   coal_cnt_t coalesced_cnt;

   // Environment side: drives the button and the controller acknowledge.
   modport master (
      output btn_raw,
      output ped_walk,
      input  ped_request,
      input  wait_lamp,
      input  coalesced_cnt
   );

   // Conditioner side.
   modport slave (
      input  btn_raw,
      input  ped_walk,
      output ped_request,
      output wait_lamp,
      output coalesced_cnt
   );
endinterface
`default_nettype wire

// File: rtl/ped_request_conditioner_btn_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises the raw button into clk and debounces it; emits a one-cycle
// press event in the cycle before the clean level rises.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module btn_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DB_W            = 5
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic btn_raw_i,
   output logic      btn_clean_o,
   output logic      press_evt_o
);
   import ped_request_conditioner_pkg::*;

   localparam logic [DB_W-1:0] C_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   clean_q;
   logic                   clean_d;
   logic [DB_W-1:0]        cnt_q;
   logic [DB_W-1:0]        cnt_d;
   logic                   w_btn_sync;
   logic                   w_mismatch;
   logic                   w_expire;

   assign w_btn_sync = sync_q[SYNC_STAGES-1];
   assign w_mismatch = (w_btn_sync != clean_q);
   assign w_expire   = w_mismatch && (cnt_q == C_DB_LAST);

   // Metastability chain: shift the raw button in from the LSB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
   end

   // Counter runs only while the synchronised input disagrees with the clean level.
   always_comb begin
      clean_d = clean_q;
      cnt_d   = '0;
      if (w_expire) begin
         clean_d = ~clean_q;
      end else if (w_mismatch) begin
         cnt_d = cnt_q + DB_W'(1);
      end
   end

   // Debounce state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_clean_o = clean_q;
   // Only the rising toggle is an event; releases are silent.
   assign press_evt_o = w_expire && !clean_q;

endmodule
`default_nettype wire

// File: rtl/ped_request_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ped_request_conditioner
// Turns the debounced pedestrian button into a latched request held until
// the controller's walk acknowledge, then enforces a cooldown window.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module ped_request_conditioner
   import ped_request_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = C_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
   parameter int DB_W            = C_DB_W,
   parameter int COOLDOWN_CYCLES = C_COOLDOWN_CYCLES,
   parameter int CD_W            = C_CD_W
) (
   input  wire logic                 clk,
   input  wire logic                 reset,
   ped_request_conditioner_if.slave  req_if
);

   localparam logic [CD_W-1:0] C_CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);

   ped_state_e      state_q, state_d;
   logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
   logic            deferred_q, deferred_d;
   coal_cnt_t       coal_q, coal_d;
   logic            ped_request_q;
   logic            wait_lamp_q;
   logic            w_press_evt;
   logic            w_btn_clean;

   btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W)
   ) u_btn_debounce (
      .clk         (clk),
      .reset       (reset),
      .btn_raw_i   (req_if.btn_raw),
      .btn_clean_o (w_btn_clean),
      .press_evt_o (w_press_evt)
   );

   // Next-state logic: request lifecycle, cooldown timing and press accounting.
   always_comb begin
      state_d    = state_q;
      cd_cnt_d   = cd_cnt_q;
      deferred_d = deferred_q;
      coal_d     = coal_q;
      unique case (state_q)
         ST_IDLE: begin
            if (w_press_evt) state_d = ST_PENDING;
         end
         ST_PENDING: begin
            if (w_press_evt)    coal_d  = sat_inc8(coal_q);
            if (req_if.ped_walk) state_d = ST_SERVING;
         end
         ST_SERVING: begin
            if (!req_if.ped_walk) begin
               state_d  = ST_COOLDOWN;
               cd_cnt_d = '0;
            end
         end
         ST_COOLDOWN: begin
            if (w_press_evt) deferred_d = 1'b1;
            if (cd_cnt_q == C_CD_LAST) begin
               state_d    = (deferred_q || w_press_evt) ? ST_PENDING : ST_IDLE;
               deferred_d = 1'b0;
               cd_cnt_d   = '0;
            end else begin
               cd_cnt_d = cd_cnt_q + CD_W'(1);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            cd_cnt_d   = '0;
            deferred_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; outputs track the next state so they align with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cd_cnt_q      <= '0;
         deferred_q    <= 1'b0;
         coal_q        <= '0;
         ped_request_q <= 1'b0;
         wait_lamp_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cd_cnt_q      <= cd_cnt_d;
         deferred_q    <= deferred_d;
         coal_q        <= coal_d;
         ped_request_q <= (state_d == ST_PENDING);
         wait_lamp_q   <= (state_d == ST_PENDING) || deferred_d;
      end
   end

   assign req_if.ped_request   = ped_request_q;
   assign req_if.wait_lamp     = wait_lamp_q;
   assign req_if.coalesced_cnt = coal_q;

   // The clean level itself is not needed here; only its press events are.
   logic w_unused;
   assign w_unused = w_btn_clean;

endmodule
`default_nettype wire
